// File: rtl/frame_buf_pkg.sv
// Shared types and constants for the frame buffer read path: pixel record,
// reader state encoding and the colour-bar palette used by the test pattern.
package frame_buf_pkg;

  localparam int PIX_DATA_WIDTH = 24;

  typedef struct packed {
    logic [PIX_DATA_WIDTH-1:0] data;
    logic                      sof;
    logic                      eol;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  // Bars run left to right in the classic order, index 0 = leftmost.
  function automatic logic [PIX_DATA_WIDTH-1:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = BAR_WHITE;
      3'd1:    bar_color = BAR_YELLOW;
      3'd2:    bar_color = BAR_CYAN;
      3'd3:    bar_color = BAR_GREEN;
      3'd4:    bar_color = BAR_MAGENTA;
      3'd5:    bar_color = BAR_RED;
      3'd6:    bar_color = BAR_BLUE;
      default: bar_color = BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/frame_buf_reader_if.sv
// Frame buffer read port plus downstream pixel stream, bundled for the reader.
// master = reader side, slave = buffer/sink side.
interface frame_buf_reader_if
  import frame_buf_pkg::*;
#(
  parameter int DATA_WIDTH = PIX_DATA_WIDTH,
  parameter int ADDR_WIDTH = 19
);

  logic                  rd_en_out;
  logic [ADDR_WIDTH-1:0] rd_addr_out;
  logic [DATA_WIDTH-1:0] rd_data_in;
  logic [DATA_WIDTH-1:0] pix_data_out;
  logic                  pix_valid_out;
  logic                  pix_ready_in;
  logic                  sof_out;
  logic                  eol_out;

  modport master (
    output rd_en_out, rd_addr_out, pix_data_out, pix_valid_out, sof_out, eol_out,
    input  rd_data_in, pix_ready_in
  );

  modport slave (
    input  rd_en_out, rd_addr_out, pix_data_out, pix_valid_out, sof_out, eol_out,
    output rd_data_in, pix_ready_in
  );

endinterface

// File: rtl/frame_buf_rd_fifo.sv
// Two-entry synchronous FIFO with occupancy count; the caller guarantees it
// never pushes when full without popping, and never pops when empty.
module frame_buf_rd_fifo #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_in,
  input  logic             pop_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [1:0]       count_out
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_in) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_in) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push_in, pop_in})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign data_out  = mem_q[rd_ptr_q];
  assign count_out = count_q;

endmodule

// File: rtl/frame_buf_reader.sv
// Read-side frame scanner: issues linear reads, absorbs the 1-cycle buffer
// latency and streams tagged pixels. Optional colour bars: FRAME_BUF_RD_PATTERN_EN.
module frame_buf_reader
  import frame_buf_pkg::*;
#(
  parameter int DATA_WIDTH = PIX_DATA_WIDTH,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int ADDR_WIDTH = 19
) (
  input  logic rd_clk,
  input  logic reset,
  input  logic start_in,
`ifdef FRAME_BUF_RD_PATTERN_EN
  input  logic pattern_sel_in,
`endif
  output logic busy_out,
  output logic frame_done_out,
  frame_buf_reader_if.master bus
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int ENTRY_W = DATA_WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic                  busy_q, busy_d;
  logic                  inflight_q, inflight_d;
  logic                  infl_sof_q, infl_sof_d;
  logic                  infl_eol_q, infl_eol_d;
`ifdef FRAME_BUF_RD_PATTERN_EN
  logic                  pattern_q, pattern_d;
  logic [DATA_WIDTH-1:0] infl_bar_q, infl_bar_d;
  logic [2:0]            bar_idx;
`endif

  logic               rd_en, pop, push, frame_done;
  logic [1:0]         fifo_count;
  logic [ENTRY_W-1:0] push_entry, head_entry;

  frame_buf_rd_fifo #(.WIDTH(ENTRY_W)) u_fifo (
    .clk      (rd_clk),
    .rst_n    (reset),
    .push_in  (push),
    .pop_in   (pop),
    .data_in  (push_entry),
    .data_out (head_entry),
    .count_out(fifo_count)
  );

  // A read may be issued only if its data is sure to find a FIFO slot, counting
  // a slot freed by a pop this cycle; rd_data_in never feeds this decision.
  always_comb begin
    pop        = (fifo_count != 2'd0) && bus.pix_ready_in;
    rd_en      = (state_q == FETCH) &&
                 ((({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'd2) || pop);
    frame_done = (state_q == DRAIN) && pop && (fifo_count == 2'd1) && !inflight_q;
    push       = inflight_q;
`ifdef FRAME_BUF_RD_PATTERN_EN
    bar_idx    = 3'((32'(x_q) * 8) / H_ACTIVE);
    push_entry = {(pattern_q ? infl_bar_q : bus.rd_data_in), infl_sof_q, infl_eol_q};
`else
    push_entry = {bus.rd_data_in, infl_sof_q, infl_eol_q};
`endif
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    x_d        = x_q;
    y_d        = y_q;
    busy_d     = busy_q;
    inflight_d = rd_en;
    infl_sof_d = infl_sof_q;
    infl_eol_d = infl_eol_q;
`ifdef FRAME_BUF_RD_PATTERN_EN
    pattern_d  = pattern_q;
    infl_bar_d = infl_bar_q;
`endif
    // Tags travel with the read so they line up with the returning data.
    if (rd_en) begin
      infl_sof_d = (x_q == '0) && (y_q == '0);
      infl_eol_d = (x_q == X_LAST);
`ifdef FRAME_BUF_RD_PATTERN_EN
      infl_bar_d = DATA_WIDTH'(bar_color(bar_idx));
`endif
    end
    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d   = FETCH;
          busy_d    = 1'b1;
          addr_d    = '0;
          x_d       = '0;
          y_d       = '0;
`ifdef FRAME_BUF_RD_PATTERN_EN
          pattern_d = pattern_sel_in;
`endif
        end
      end
      FETCH: begin
        if (rd_en) begin
          addr_d = addr_q + 1'b1;
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
          if (addr_q == LAST_ADDR) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (frame_done) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      busy_q     <= 1'b0;
      inflight_q <= 1'b0;
      infl_sof_q <= 1'b0;
      infl_eol_q <= 1'b0;
`ifdef FRAME_BUF_RD_PATTERN_EN
      pattern_q  <= 1'b0;
      infl_bar_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      infl_sof_q <= infl_sof_d;
      infl_eol_q <= infl_eol_d;
`ifdef FRAME_BUF_RD_PATTERN_EN
      pattern_q  <= pattern_d;
      infl_bar_q <= infl_bar_d;
`endif
    end
  end

  assign bus.rd_en_out     = rd_en;
  assign bus.rd_addr_out   = addr_q;
  assign bus.pix_valid_out = (fifo_count != 2'd0);
  assign {bus.pix_data_out, bus.sof_out, bus.eol_out} = head_entry;
  assign busy_out          = busy_q;
  assign frame_done_out    = frame_done;

endmodule

// File: tb/tb_frame_buf_reader.sv
// Self-checking bench for frame_buf_reader on a 4x2 frame with a memory model
// returning addr+1; colour-bar row only when FRAME_BUF_RD_PATTERN_EN is defined.
module tb_frame_buf_reader;
  import frame_buf_pkg::*;

  localparam int DW   = 24;
  localparam int HA   = 4;
  localparam int VA   = 2;
  localparam int AW   = 4;
  localparam int NPIX = HA * VA;

  typedef struct {
    logic [3:0] ready_mask;
    bit         mid_start;
    bit         pattern;
    int         exp_pixels;
    int         exp_reads;
    int         exp_first_valid;
    int         exp_done_k;
  } vec_t;

  logic rd_clk = 1'b0;
  logic reset = 1'b0;
  logic start_in = 1'b0;
  logic pattern_sel_in = 1'b0;
  logic busy_out, frame_done_out;

  frame_buf_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  frame_buf_reader #(
    .DATA_WIDTH(DW), .H_ACTIVE(HA), .V_ACTIVE(VA), .ADDR_WIDTH(AW)
  ) dut (
    .rd_clk        (rd_clk),
    .reset         (reset),
    .start_in      (start_in),
`ifdef FRAME_BUF_RD_PATTERN_EN
    .pattern_sel_in(pattern_sel_in),
`endif
    .busy_out      (busy_out),
    .frame_done_out(frame_done_out),
    .bus           (bus.master)
  );

  always #5 rd_clk = ~rd_clk;

  // Buffer model: data is addr+1 one cycle after the strobe, junk otherwise.
  always @(posedge rd_clk)
    bus.rd_data_in <= bus.rd_en_out ? (DW'(bus.rd_addr_out) + 24'd1) : 24'hA5A5A5;

  int          nVec = 0;
  int          nFail = 0;
  pixel_t      expPix[$];
  logic [AW-1:0] expAddr[$];
  vec_t        vecs[$];
  int          reads, pops, maxOut, firstValidK, doneK;
  bit          prevStall;
  logic [25:0] prevPix;

  task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] barExp(input int x);
    case (x)
      0:       barExp = 24'hFFFFFF;
      1:       barExp = 24'h00FFFF;
      2:       barExp = 24'hFF00FF;
      default: barExp = 24'h0000FF;
    endcase
  endfunction

  task automatic applyStimulus(input logic rstN, input logic st, input logic rdy, input logic pat);
    @(posedge rd_clk);
    #1;
    reset            = rstN;
    start_in         = st;
    bus.pix_ready_in = rdy;
    pattern_sel_in   = pat;
  endtask

  task automatic resetMonitor();
    reads = 0; pops = 0; maxOut = 0; firstValidK = -1; doneK = -1; prevStall = 1'b0;
    prevPix = '0;
  endtask

  task automatic loadExpect(input bit pat);
    pixel_t e;
    for (int i = 0; i < NPIX; i++) begin
      e.data = pat ? barExp(i % HA) : DW'(i + 1);
      e.sof  = (i == 0);
      e.eol  = ((i % HA) == HA - 1);
      expPix.push_back(e);
      expAddr.push_back(AW'(i));
    end
  endtask

  task automatic checkOutput(input int k);
    pixel_t e;
    @(negedge rd_clk);
    if (bus.rd_en_out) begin
      reads++;
      if (expAddr.size() > 0) checkEq("rd_addr", 64'(bus.rd_addr_out), 64'(expAddr.pop_front()));
    end
    if (prevStall)
      checkEq("stall_hold", {bus.pix_valid_out, bus.pix_data_out, bus.sof_out, bus.eol_out},
              {1'b1, prevPix});
    prevStall = bus.pix_valid_out && !bus.pix_ready_in;
    prevPix   = {bus.pix_data_out, bus.sof_out, bus.eol_out};
    if (bus.pix_valid_out && firstValidK < 0) firstValidK = k;
    if (bus.pix_valid_out && bus.pix_ready_in) begin
      pops++;
      if (expPix.size() > 0) begin
        e = expPix.pop_front();
        checkEq("pixel", {bus.pix_data_out, bus.sof_out, bus.eol_out}, e);
        checkEq("frame_done_on_pop", frame_done_out, expPix.size() == 0);
      end
    end
    if (frame_done_out && doneK < 0) doneK = k;
    if (reads - pops > maxOut) maxOut = reads - pops;
  endtask

  task automatic checkZero(input string name);
    @(negedge rd_clk);
    checkEq(name, {bus.rd_en_out, bus.rd_addr_out, bus.pix_data_out, bus.pix_valid_out,
                   bus.sof_out, bus.eol_out, busy_out, frame_done_out}, 64'd0);
  endtask

  task automatic runFrame(input vec_t v);
    int k;
    resetMonitor();
    loadExpect(v.pattern);
    applyStimulus(1'b1, 1'b1, 1'b1, v.pattern);
    k = 0;
    while (doneK < 0 && k < 100) begin
      applyStimulus(1'b1, v.mid_start && (k == 3), v.ready_mask[k % 4], v.pattern);
      checkOutput(k);
      if (k == 0) checkEq("busy_on_accept", busy_out, 1);
      k++;
    end
    checkEq("frame_done_seen", doneK >= 0, 1);
    if (v.exp_done_k >= 0) checkEq("done_cycle", doneK, v.exp_done_k);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput(k);
    checkEq("busy_after_done", busy_out, 0);
    checkEq("idle_no_read", bus.rd_en_out, 0);
    checkEq("pixel_count", pops, v.exp_pixels);
    checkEq("read_count", reads, v.exp_reads);
    checkEq("first_valid_cycle", firstValidK, v.exp_first_valid);
    checkEq("outstanding_le_2", maxOut <= 2, 1);
    checkEq("scoreboard_empty", expPix.size(), 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.pix_ready_in = 1'b0;
    vecs.push_back('{4'b1111, 1'b0, 1'b0, NPIX, NPIX, 2, 9});
    vecs.push_back('{4'b1001, 1'b0, 1'b0, NPIX, NPIX, 2, -1});
    vecs.push_back('{4'b1111, 1'b1, 1'b0, NPIX, NPIX, 2, 9});
    vecs.push_back('{4'b0110, 1'b0, 1'b0, NPIX, NPIX, 2, -1});
    vecs.push_back('{4'b0100, 1'b1, 1'b0, NPIX, NPIX, 2, -1});
`ifdef FRAME_BUF_RD_PATTERN_EN
    vecs.push_back('{4'b1111, 1'b0, 1'b1, NPIX, NPIX, 2, 9});
`endif

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkZero("reset_hold");
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      checkZero("idle_no_start");
    end

    foreach (vecs[i]) runFrame(vecs[i]);

    // Reset lands after the third pixel; the next frame must start clean.
    resetMonitor();
    loadExpect(1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput(k);
    end
    checkEq("pops_before_reset", pops, 3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge rd_clk);
    checkEq("mid_reset_zero", {bus.rd_en_out, bus.rd_addr_out, bus.pix_data_out, bus.pix_valid_out,
                               bus.sof_out, bus.eol_out, busy_out, frame_done_out}, 64'd0);
    expPix.delete();
    expAddr.delete();
    runFrame(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
